// File: rtl/counter_rr_sched_if.sv
// counter_rr_sched_if
// Bundles the requester handshake and the shared-counter control/readback
// signals seen by counter_rr_sched.
//   req        : per-requester level request (requesters -> scheduler)
//   gnt        : one-hot grant, all-zero when idle (scheduler -> requesters)
//   done / err : burst-complete pulse and bad-final-count pulse
//   cnt_clear  : clear strobe to the shared mod-8 counter
//   cnt_enable : count enable to the shared counter
//   cnt_value  : current counter value read back by the scheduler
// Modport master is the scheduler side; slave is the requester/counter side.
interface counter_rr_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             done;
    logic             err;
    logic             cnt_clear;
    logic             cnt_enable;
    logic [2:0]       cnt_value;

    modport master (
        input  req,
        input  cnt_value,
        output gnt,
        output done,
        output err,
        output cnt_clear,
        output cnt_enable
    );

    modport slave (
        output req,
        output cnt_value,
        input  gnt,
        input  done,
        input  err,
        input  cnt_clear,
        input  cnt_enable
    );
endinterface

// File: rtl/counter_rr_sched.sv
// counter_rr_sched
// Round-robin scheduler sharing one 3-bit mod-8 counter among N_REQ
// requesters. A granted requester owns the counter for BURST enabled counts;
// the scheduler clears the counter before each burst and checks the final
// value when the burst ends.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : counter_rr_sched_if.master (req, gnt, done, err,
//           cnt_clear, cnt_enable, cnt_value)
// All outputs are decoded from registered state; req never reaches gnt
// combinationally.
module counter_rr_sched #(
    parameter int N_REQ = 4,
    parameter int BURST = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    counter_rr_sched_if.master    bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [2:0] RUN_LAST  = 3'(BURST - 1);
    localparam logic [2:0] CNT_FINAL = 3'(BURST % 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q,   state_d;
    logic [N_REQ-1:0]   gnt_q,     gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   last_q,    last_d;
    logic [2:0]         run_cnt_q, run_cnt_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               gnt_active;

    // Round-robin search: first set req bit after last_q, wrapping mod N_REQ.
    always_comb begin
        int             idx;
        logic [IDX_W-1:0] cand;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(last_q) + k) % N_REQ;
            cand = IDX_W'(idx);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // The granted requester still holding its request; low means abort.
    assign gnt_active = |(bus.req & gnt_q);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        last_d    = last_q;
        run_cnt_d = run_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gnt_idx_d       = pick_idx;
                    state_d         = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!gnt_active) begin
                    // Abort consumes the requester's turn.
                    gnt_d   = '0;
                    last_d  = gnt_idx_q;
                    state_d = S_IDLE;
                end else begin
                    run_cnt_d = 3'd0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (!gnt_active) begin
                    gnt_d   = '0;
                    last_d  = gnt_idx_q;
                    state_d = S_IDLE;
                end else begin
                    run_cnt_d = run_cnt_q + 3'd1;
                    if (run_cnt_q == RUN_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                last_d  = gnt_idx_q;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            run_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            last_q    <= last_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.cnt_clear  = (state_q == S_CLEAR);
    assign bus.cnt_enable = (state_q == S_RUN);
    assign bus.done       = (state_q == S_DONE);
    // The final count is judged in the same cycle done is shown.
    assign bus.err        = (state_q == S_DONE) && (bus.cnt_value != CNT_FINAL);
endmodule

// File: tb/tb_counter_rr_sched.sv
module tb_counter_rr_sched;
    typedef struct packed {
        logic       abort;
        logic [3:0] gnt;
        logic       err;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    logic       force_en;
    logic [2:0] force_val;
    logic [2:0] cnt_a = 3'd0;
    logic [2:0] cnt_b = 3'd0;

    counter_rr_sched_if #(.N_REQ(4)) ifa ();
    counter_rr_sched_if #(.N_REQ(4)) ifb ();

    counter_rr_sched #(.N_REQ(4), .BURST(5)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    counter_rr_sched #(.N_REQ(4), .BURST(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared mod-8 counter models; A can be overridden to emulate a faulty counter.
    always @(posedge clk) begin
        if (ifa.cnt_clear)       cnt_a <= 3'd0;
        else if (ifa.cnt_enable) cnt_a <= cnt_a + 3'd1;
        if (ifb.cnt_clear)       cnt_b <= 3'd0;
        else if (ifb.cnt_enable) cnt_b <= cnt_b + 3'd1;
    end
    assign ifa.cnt_value = force_en ? force_val : cnt_a;
    assign ifb.cnt_value = cnt_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic ab, input logic [3:0] g, input logic e);
        exp_t r;
        r.abort = ab;
        r.gnt   = g;
        r.err   = e;
        exp_q.push_back(r);
    endtask

    task automatic wait_a(input bit for_done, input int budget);
        int n;
        n = 0;
        while (((for_done ? ifa.done : |ifa.gnt) == 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(for_done ? "wait_done_a" : "wait_gnt_a", for_done ? ifa.done : |ifa.gnt, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0] prev_gnt;
    logic       prev_done;
    exp_t       mon_e;
    int         en_cnt;
    bit         seen7;
    logic [3:0] order [5];

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        force_en  = 1'b0;
        force_val = 3'd0;
        ifa.req   = 4'b0000;
        ifb.req   = 4'b0000;
        prev_gnt  = 4'b0000;
        prev_done = 1'b0;

        // Monitor: pops one expected record per burst end (done) or per
        // grant withdrawn without done (abort or reset).
        fork
            forever begin
                @(negedge clk);
                chk("gnt_onehot0", $onehot0(ifa.gnt), 1);
                chk("clr_en_excl", ifa.cnt_clear & ifa.cnt_enable, 0);
                if (ifa.done) begin
                    chk("sb_have_done_rec", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("sb_done", {1'b0, ifa.gnt, ifa.err}, mon_e);
                    end
                end else if (prev_gnt != 4'b0000 && ifa.gnt == 4'b0000 && !prev_done) begin
                    chk("sb_have_abort_rec", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("sb_abort", {1'b1, prev_gnt, ifa.err | ifa.done}, mon_e);
                    end
                end
                prev_gnt  = ifa.gnt;
                prev_done = ifa.done;
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", ifa.gnt, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_err", ifa.err, 0);
        chk("rst_clear", ifa.cnt_clear, 0);
        chk("rst_enable", ifa.cnt_enable, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_req_gnt", ifa.gnt, 0);

        // Single burst, BURST=5
        ifa.req = 4'b0001;
        push(1'b0, 4'b0001, 1'b0);
        @(negedge clk);
        chk("t1_gnt", ifa.gnt, 4'b0001);
        chk("t1_clear", ifa.cnt_clear, 1);
        en_cnt = 0;
        for (int i = 0; i < 20 && !ifa.done; i++) begin
            @(negedge clk);
            if (ifa.cnt_enable) en_cnt++;
        end
        chk("t1_done", ifa.done, 1);
        chk("t1_enable_cycles", en_cnt, 5);
        chk("t1_cnt_final", ifa.cnt_value, 5);
        chk("t1_err", ifa.err, 0);
        ifa.req = 4'b0000;
        @(negedge clk);
        chk("t1_gnt_after", ifa.gnt, 0);

        // BURST=8 wrap on instance B
        ifb.req = 4'b0001;
        @(negedge clk);
        chk("t3_gnt", ifb.gnt, 4'b0001);
        en_cnt = 0;
        seen7  = 1'b0;
        for (int i = 0; i < 20 && !ifb.done; i++) begin
            @(negedge clk);
            if (ifb.cnt_enable) en_cnt++;
            if (ifb.cnt_enable && ifb.cnt_value == 3'd7) seen7 = 1'b1;
        end
        chk("t3_done", ifb.done, 1);
        chk("t3_enable_cycles", en_cnt, 8);
        chk("t3_saw_7", seen7, 1);
        chk("t3_cnt_wrap", ifb.cnt_value, 0);
        chk("t3_err", ifb.err, 0);
        ifb.req = 4'b0000;
        @(negedge clk);

        // Fairness with all requests held
        do_reset();
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b0100;
        order[3] = 4'b1000;
        order[4] = 4'b0001;
        for (int i = 0; i < 5; i++) push(1'b0, order[i], 1'b0);
        ifa.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_a(1'b1, 20);
            if (i == 4) ifa.req = 4'b0000;
            @(negedge clk);
            chk("t2_idle_gap", ifa.gnt, 0);
            if (i < 4) begin
                @(negedge clk);
                chk("t2_next_gnt", ifa.gnt, order[i + 1]);
            end
        end
        @(negedge clk);
        chk("t2_all_done", exp_q.size(), 0);

        // Faulty final count -> err alongside done
        ifa.req   = 4'b0100;
        force_en  = 1'b1;
        force_val = 3'd3;
        push(1'b0, 4'b0100, 1'b1);
        wait_a(1'b1, 20);
        chk("t4_err", ifa.err, 1);
        ifa.req  = 4'b0000;
        force_en = 1'b0;
        @(negedge clk);
        chk("t4_err_clear", ifa.err, 0);
        chk("t4_done_clear", ifa.done, 0);

        // Abort in third RUN cycle, then turn consumed
        ifa.req = 4'b0100;
        push(1'b1, 4'b0100, 1'b0);
        wait_a(1'b0, 10);
        repeat (3) @(negedge clk);
        chk("t5_in_run", ifa.cnt_enable, 1);
        ifa.req = 4'b0000;
        @(negedge clk);
        chk("t5_gnt", ifa.gnt, 0);
        chk("t5_enable", ifa.cnt_enable, 0);
        chk("t5_no_done", ifa.done, 0);
        chk("t5_partial_cnt", ifa.cnt_value, 3);
        ifa.req = 4'b1100;
        push(1'b0, 4'b1000, 1'b0);
        @(negedge clk);
        chk("t5_regrant", ifa.gnt, 4'b1000);
        wait_a(1'b1, 20);
        ifa.req = 4'b0000;
        @(negedge clk);

        // Reset mid-RUN with requests held
        ifa.req = 4'b0011;
        push(1'b0, 4'b0001, 1'b0);
        push(1'b1, 4'b0010, 1'b0);
        push(1'b0, 4'b0001, 1'b0);
        wait_a(1'b1, 20);
        @(negedge clk);
        wait_a(1'b0, 10);
        chk("t6_second_gnt", ifa.gnt, 4'b0010);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_gnt", ifa.gnt, 0);
        chk("t6_rst_enable", ifa.cnt_enable, 0);
        chk("t6_rst_clear", ifa.cnt_clear, 0);
        chk("t6_rst_done", ifa.done, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_post_rst_gnt", ifa.gnt, 4'b0001);
        wait_a(1'b1, 20);
        ifa.req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
